// File: rtl/int_stimulus_gen.sv
// Multi-channel interrupt injector: each channel watches the CPU PC for its target,
// optionally waits DELAY cycles, then holds a request until acked (level) or for PULSE_W cycles (pulse).
module int_stimulus_gen #(
   parameter int unsigned       NCH        = 2,
   parameter logic [NCH*32-1:0] TARGET_PCS = {32'h3020, 32'h3010},
   parameter int unsigned       FIRE_LIMIT = 1,
   parameter int unsigned       DELAY      = 0,
   parameter int unsigned       MODE       = 0,
   parameter int unsigned       PULSE_W    = 1,
   parameter logic [31:0]       ACK_ADDR   = 32'h7f20,
   parameter int unsigned       TIMEOUT    = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [31:0]      macroscopic_pc,
   input  logic [31:0]      m_int_addr,
   input  logic [3:0]       m_int_byteen,
   output logic [NCH-1:0]   int_vec,
   output logic             interrupt,
   output logic [NCH*8-1:0] fire_cnt,
   output logic [NCH-1:0]   timeout_err,
   output logic             busy,
   output logic [NCH*2-1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ASSERT = 2'd2
   } state_e;

   logic [31:0]    pc_w;
   logic [31:0]    addr_w;
   logic           store_w;
   logic [NCH-1:0] busy_w;

   assign pc_w    = macroscopic_pc & 32'hffff_fffc;
   assign addr_w  = m_int_addr & 32'hffff_fffc;
   assign store_w = |m_int_byteen;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam logic [31:0] TARGET = TARGET_PCS[32*i +: 32];
      localparam logic [31:0] ACK_I  = ACK_ADDR + 32'(4 * i);

      state_e      state_q, state_d;
      logic [7:0]  dcnt_q, dcnt_d;
      logic [7:0]  fcnt_q, fcnt_d;
      logic [31:0] tcnt_q, tcnt_d;
      logic        armed_q, armed_d;
      logic        terr_q, terr_d;
      logic        ivec_q, ivec_d;
      logic        busy_bit;
      logic        pc_hit, under_limit, match, ack_ok, tmo_hit, pulse_done;

      assign pc_hit      = (pc_w == TARGET);
      assign under_limit = (FIRE_LIMIT == 0) || (32'(fcnt_q) < FIRE_LIMIT);
      assign match       = enable && armed_q && pc_hit && under_limit;
      // Only acks seen while the request is already visible count.
      assign ack_ok      = store_w && (addr_w == ACK_I) && ivec_q;
      assign tmo_hit     = (MODE == 0) && (TIMEOUT != 0) && (tcnt_q == TIMEOUT - 1);
      assign pulse_done  = (tcnt_q == PULSE_W - 1);

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= ST_IDLE;
            dcnt_q  <= '0;
            fcnt_q  <= '0;
            tcnt_q  <= '0;
            armed_q <= 1'b1;
            terr_q  <= 1'b0;
            ivec_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            fcnt_q  <= fcnt_d;
            tcnt_q  <= tcnt_d;
            armed_q <= armed_d;
            terr_q  <= terr_d;
            ivec_q  <= ivec_d;
         end
      end

      always_comb begin
         state_d = state_q;
         case (state_q)
            ST_IDLE:   if (match) state_d = (DELAY == 0) ? ST_ASSERT : ST_WAIT;
            ST_WAIT:   if (dcnt_q == 8'd1) state_d = ST_ASSERT;
            ST_ASSERT: begin
               if (MODE == 1) begin
                  if (pulse_done) state_d = ST_IDLE;
               end else if (ack_ok || tmo_hit) begin
                  state_d = ST_IDLE;
               end
            end
            default:   state_d = ST_IDLE;
         endcase
      end

      always_comb begin
         dcnt_d  = dcnt_q;
         tcnt_d  = tcnt_q;
         fcnt_d  = fcnt_q;
         terr_d  = terr_q;
         armed_d = armed_q;
         if (!pc_hit) armed_d = 1'b1;
         else if (match) armed_d = 1'b0;
         if (state_q == ST_IDLE && state_d == ST_WAIT) dcnt_d = 8'(DELAY);
         else if (state_q == ST_WAIT) dcnt_d = dcnt_q - 8'd1;
         if (state_q != ST_ASSERT && state_d == ST_ASSERT) begin
            tcnt_d = '0;
            if (fcnt_q != 8'hff) fcnt_d = fcnt_q + 8'd1;
         end else if (state_q == ST_ASSERT) begin
            tcnt_d = tcnt_q + 32'd1;
         end
         // An ack landing on the timeout cycle wins; no error is flagged.
         if (state_q == ST_ASSERT && tmo_hit && !ack_ok) terr_d = 1'b1;
      end

      always_comb begin
         ivec_d   = (state_q == ST_ASSERT);
         busy_bit = (state_q != ST_IDLE);
      end

      assign int_vec[i]           = ivec_q;
      assign fire_cnt[8*i +: 8]   = fcnt_q;
      assign timeout_err[i]       = terr_q;
      assign dbg_state[2*i +: 2]  = state_q;
      assign busy_w[i]            = busy_bit;
   end

   assign interrupt = |int_vec;
   assign busy      = |busy_w;

endmodule
